// File: rtl/mcu_playlist.sv
// Playlist controller: PAUSE/PLAY/CHANGE state machine tracking the current song index.
// Optional feature macro MCU_PLAYLIST_AUTOPLAY_EN: song_done-initiated changes resume playback.
module mcu_playlist #(
   parameter int NUM_SONGS = 4,
   parameter int SONG_W    = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play_button,
   input  logic              next_button,
   input  logic              prev_button,
   input  logic [1:0]        mode,
   input  logic              song_done,
   output logic              play,
   output logic              reset_player,
   output logic [SONG_W-1:0] song,
   output logic              playlist_done
);

   typedef enum logic [1:0] {
      PAUSE  = 2'b00,
      PLAY   = 2'b01,
      CHANGE = 2'b10
   } state_t;

   localparam logic [SONG_W-1:0] LAST_SONG  = SONG_W'(NUM_SONGS - 1);
   localparam logic [SONG_W-1:0] FIRST_SONG = '0;

   localparam logic [1:0] MODE_REPEAT_ALL = 2'b01;
   localparam logic [1:0] MODE_REPEAT_ONE = 2'b10;

   state_t            state_reg, state_next;
   logic [SONG_W-1:0] song_reg, song_next;
   logic              done_reg, done_next;
   logic [SONG_W-1:0] song_inc, song_dec;
   logic [SONG_W-1:0] done_target;
   logic              done_is_end;

   // Explicit compare-and-wrap keeps the index legal for non-power-of-two lists.
   always_comb begin
      song_inc = (song_reg == LAST_SONG)  ? FIRST_SONG : song_reg + 1'b1;
      song_dec = (song_reg == FIRST_SONG) ? LAST_SONG  : song_reg - 1'b1;
   end

   always_comb begin
      done_target = song_inc;
      done_is_end = 1'b0;
      case (mode)
         MODE_REPEAT_ONE: done_target = song_reg;
         MODE_REPEAT_ALL: done_target = song_inc;
         default: begin
            done_target = song_inc;
            done_is_end = (song_reg == LAST_SONG);
         end
      endcase
   end

`ifdef MCU_PLAYLIST_AUTOPLAY_EN
   logic resume_reg, resume_next;
`endif

   always_comb begin
      state_next = state_reg;
      song_next  = song_reg;
      done_next  = 1'b0;
`ifdef MCU_PLAYLIST_AUTOPLAY_EN
      resume_next = 1'b0;
`endif
      case (state_reg)
         PAUSE: begin
            if (play_button) begin
               state_next = PLAY;
            end else if (next_button) begin
               state_next = CHANGE;
               song_next  = song_inc;
            end else if (prev_button) begin
               state_next = CHANGE;
               song_next  = song_dec;
            end
         end
         PLAY: begin
            if (play_button) begin
               state_next = PAUSE;
            end else if (next_button) begin
               state_next = CHANGE;
               song_next  = song_inc;
            end else if (prev_button) begin
               state_next = CHANGE;
               song_next  = song_dec;
            end else if (song_done) begin
               state_next = CHANGE;
               song_next  = done_target;
               done_next  = done_is_end;
`ifdef MCU_PLAYLIST_AUTOPLAY_EN
               // Running off the end of a normal playlist always stops playback.
               resume_next = !done_is_end;
`endif
            end
         end
         CHANGE: begin
`ifdef MCU_PLAYLIST_AUTOPLAY_EN
            state_next = resume_reg ? PLAY : PAUSE;
`else
            state_next = PAUSE;
`endif
         end
         default: begin
            state_next = PAUSE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= PAUSE;
         song_reg  <= FIRST_SONG;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         song_reg  <= song_next;
         done_reg  <= done_next;
      end
   end

`ifdef MCU_PLAYLIST_AUTOPLAY_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resume_reg <= 1'b0;
      end else begin
         resume_reg <= resume_next;
      end
   end
`endif

   assign play          = (state_reg == PLAY);
   assign reset_player  = (state_reg == CHANGE);
   assign song          = song_reg;
   assign playlist_done = done_reg;

endmodule

// File: tb/tb_mcu_playlist.sv
// Directed bench for mcu_playlist (NUM_SONGS=3): driver queues expected outputs, monitor compares.
`timescale 1ns/1ps
module tb_mcu_playlist;

   localparam int NUM_SONGS = 3;
   localparam int SONG_W    = 2;

   typedef struct packed {
      logic              play;
      logic              reset_player;
      logic [SONG_W-1:0] song;
      logic              playlist_done;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              play_button, next_button, prev_button, song_done;
   logic [1:0]        mode;
   logic              play, reset_player, playlist_done;
   logic [SONG_W-1:0] song;

   int   tests_run = 0;
   int   tests_failed = 0;
   int   step_id = 0;
   exp_t exp_q[$];
   event check_ev;

   mcu_playlist #(.NUM_SONGS(NUM_SONGS), .SONG_W(SONG_W)) dut (
      .clk(clk), .reset(reset),
      .play_button(play_button), .next_button(next_button), .prev_button(prev_button),
      .mode(mode), .song_done(song_done),
      .play(play), .reset_player(reset_player), .song(song), .playlist_done(playlist_done)
   );

   always #5 clk = ~clk;

   // Monitor: one expected entry per sample point.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or check_ev);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if ({play, reset_player, song, playlist_done} !== e) begin
               tests_failed++;
               $display("FAIL step%0d got play=%b rp=%b song=%0d pd=%b expected play=%b rp=%b song=%0d pd=%b",
                        step_id, play, reset_player, song, playlist_done,
                        e.play, e.reset_player, e.song, e.playlist_done);
            end else begin
               $display("[TB] step%0d ok play=%b rp=%b song=%0d pd=%b",
                        step_id, play, reset_player, song, playlist_done);
            end
         end
      end
   end

   task automatic push(input logic p, input logic rp, input int s, input logic pd);
      exp_t e;
      e.play = p; e.reset_player = rp; e.song = SONG_W'(s); e.playlist_done = pd;
      exp_q.push_back(e);
   endtask

   // Drive one cycle of inputs; expected outputs are those after the next rising edge.
   task automatic cy(input logic pb, input logic nb, input logic vb, input logic [1:0] md,
                     input logic sd, input logic p, input logic rp, input int s, input logic pd);
      step_id++;
      play_button = pb; next_button = nb; prev_button = vb; mode = md; song_done = sd;
      push(p, rp, s, pd);
      @(posedge clk);
      #1;
      play_button = 1'b0; next_button = 1'b0; prev_button = 1'b0; song_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic async_reset_check();
      step_id++;
      reset = 1'b0;
      #1;
      push(0, 0, 0, 0);
      ->check_ev;
      #1;
   endtask

   initial begin
      #50000;
      tests_failed++;
      $display("FAIL watchdog expired");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; play_button = 0; next_button = 0; prev_button = 0; song_done = 0; mode = 2'b00;
      #2;
      step_id++;
      push(0, 0, 0, 0);
      ->check_ev;
      @(negedge clk);
      reset = 1'b1;

      cy(1,0,0,2'b00,0, 1,0,0,0);   // play
      cy(0,1,0,2'b00,0, 0,1,1,0);   // next from PLAY
      cy(0,0,0,2'b00,0, 0,0,1,0);   // exit to PAUSE
      cy(0,0,1,2'b00,0, 0,1,0,0);   // prev
      cy(0,0,0,2'b00,0, 0,0,0,0);
      cy(0,0,1,2'b00,0, 0,1,2,0);   // prev wraps 0 -> 2
      cy(0,0,0,2'b00,0, 0,0,2,0);
      cy(0,1,0,2'b00,0, 0,1,0,0);   // next wraps 2 -> 0
      cy(0,0,0,2'b00,0, 0,0,0,0);
      cy(0,0,0,2'b00,1, 0,0,0,0);   // song_done ignored in PAUSE
      cy(1,0,0,2'b00,0, 1,0,0,0);
      cy(0,1,1,2'b00,0, 0,1,1,0);   // next beats prev
      cy(0,0,0,2'b00,0, 0,0,1,0);
      cy(1,0,0,2'b00,0, 1,0,1,0);
      cy(0,0,0,2'b10,1, 0,1,1,0);   // repeat-one keeps index
`ifdef MCU_PLAYLIST_AUTOPLAY_EN
      cy(0,0,0,2'b00,0, 1,0,1,0);
`else
      cy(0,0,0,2'b00,0, 0,0,1,0);
      cy(1,0,0,2'b00,0, 1,0,1,0);
`endif
      cy(0,0,0,2'b01,1, 0,1,2,0);   // repeat-all advance
`ifdef MCU_PLAYLIST_AUTOPLAY_EN
      cy(0,0,0,2'b00,0, 1,0,2,0);
`else
      cy(0,0,0,2'b00,0, 0,0,2,0);
      cy(1,0,0,2'b00,0, 1,0,2,0);
`endif
      cy(1,0,0,2'b00,1, 0,0,2,0);   // play_button outranks song_done
      cy(1,0,0,2'b00,0, 1,0,2,0);
      cy(0,0,0,2'b00,1, 0,1,0,1);   // normal mode past last song
      cy(0,1,0,2'b01,0, 0,0,0,0);   // inputs ignored in CHANGE, exit PAUSE
      cy(1,0,0,2'b00,0, 1,0,0,0);
      cy(0,0,0,2'b11,1, 0,1,1,0);   // mode 11 acts as normal
`ifdef MCU_PLAYLIST_AUTOPLAY_EN
      cy(0,0,0,2'b00,0, 1,0,1,0);
      cy(1,0,0,2'b00,0, 0,0,1,0);
`else
      cy(0,0,0,2'b00,0, 0,0,1,0);
`endif
      cy(0,1,0,2'b00,0, 0,1,2,0);
      cy(0,0,0,2'b00,0, 0,0,2,0);
      cy(1,0,0,2'b00,0, 1,0,2,0);   // PLAY with song=2

      @(posedge clk);
      #2;
      async_reset_check();          // immediate reset mid-PLAY
      @(negedge clk);
      cy(1,0,0,2'b00,0, 0,0,0,0);   // held in reset
      reset = 1'b1;
      cy(0,1,0,2'b00,0, 0,1,1,0);   // CHANGE toward song 1
      async_reset_check();          // abort the change
      reset = 1'b1;
      cy(0,0,0,2'b00,0, 0,0,0,0);
      cy(0,0,1,2'b00,0, 0,1,2,0);
      cy(0,0,0,2'b00,0, 0,0,2,0);

      @(negedge clk);
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL leftover_expectations got %0d required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mcu_playlist.md
MCU_PLAYLIST -- requirements
Module: mcu_playlist

Interface
REQ-001 Parameter: NUM_SONGS, default 4, number of playlist entries; legal range 2..256, need not be a power of two.
REQ-002 Parameter: SONG_W, default 2, song index width; SHALL satisfy 2**SONG_W >= NUM_SONGS.
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: play_button  input  1  one-cycle pulse; toggles play/pause.
REQ-006 Port: next_button  input  1  one-cycle pulse; advance to next song.
REQ-007 Port: prev_button  input  1  one-cycle pulse; go back to previous song.
REQ-008 Port: mode  input  2  00 normal, 01 repeat-all, 10 repeat-one, 11 treated as normal.
REQ-009 Port: song_done  input  1  one-cycle pulse from player at end of current song.
REQ-010 Port: play  output  1  high only in PLAY state.
REQ-011 Port: reset_player  output  1  high only in CHANGE state.
REQ-012 Port: song  output  SONG_W  current song index, registered.
REQ-013 Port: playlist_done  output  1  registered one-cycle pulse when normal mode runs past the last song.

Function
REQ-014 States SHALL be PAUSE, PLAY and CHANGE; any unused encoding SHALL go to PAUSE on the next edge with song unchanged.
REQ-015 Button priority in PAUSE and PLAY SHALL be play_button > next_button > prev_button; lower-priority simultaneous pulses are dropped.
REQ-016 PAUSE: play_button -> PLAY; next_button or prev_button -> CHANGE; song_done ignored.
REQ-017 PLAY: play_button -> PAUSE; next_button or prev_button -> CHANGE; otherwise song_done -> CHANGE; play_button outranks a simultaneous song_done.
REQ-018 CHANGE SHALL last exactly one cycle; all inputs in CHANGE SHALL be ignored; the exit state is per REQ-024.
REQ-019 song SHALL be updated on the same edge that enters CHANGE, so reset_player is asserted with the new index already on song.
REQ-020 next_button: song+1, wrapping from NUM_SONGS-1 to 0, in every mode.
REQ-021 prev_button: song-1, wrapping from 0 to NUM_SONGS-1, in every mode.
REQ-022 song_done target: repeat-one -> same index; repeat-all -> song+1 with wrap; normal -> song+1, or 0 when song==NUM_SONGS-1.
REQ-023 playlist_done SHALL pulse on the CHANGE-entry edge only for the case normal mode, song_done, song==NUM_SONGS-1; it is low at all other times.
REQ-024 CHANGE exit: PAUSE after any button-initiated change; after a song_done-initiated change, per the Configuration section, except that playlist_done always exits to PAUSE.
REQ-025 Index arithmetic SHALL be done in SONG_W bits with explicit compare-and-wrap; song SHALL never hold a value >= NUM_SONGS.
REQ-026 mode SHALL be sampled only on the edge that enters CHANGE; mid-song mode changes affect only the next transition.

Reset
REQ-027 Asserting reset low SHALL immediately force state=PAUSE, song=0, play=0, reset_player=0, playlist_done=0, independent of clk.
REQ-028 Reset during CHANGE SHALL abort the change; the pending target index SHALL be discarded.
REQ-029 After reset is released, the first state update SHALL occur on the first rising clk edge.

Configuration
REQ-030 Macro MCU_PLAYLIST_AUTOPLAY_EN defined: a song_done-initiated CHANGE SHALL exit to PLAY, so continuous playback runs through the playlist.
REQ-031 Macro MCU_PLAYLIST_AUTOPLAY_EN undefined: every CHANGE SHALL exit to PAUSE.

Verification
REQ-032 Reset low mid-PLAY with song=2 -> play=0, song=0, reset_player=0 immediately, with no clk edge needed.
REQ-033 NUM_SONGS=3, PAUSE, song=2, next_button pulse -> next cycle CHANGE with song=0 and reset_player=1; cycle after that PAUSE.
REQ-034 PAUSE, song=0, prev_button pulse -> song=NUM_SONGS-1 with reset_player high for exactly one cycle.
REQ-035 PLAY, song=1, mode=10, song_done -> song stays 1 with reset_player=1 for one cycle; exit is PLAY with AUTOPLAY_EN defined, PAUSE without.
REQ-036 PLAY, mode=00, song=NUM_SONGS-1, song_done -> song=0, playlist_done=1 for one cycle, exit to PAUSE in both macro builds.
REQ-037 PLAY, play_button and song_done in the same cycle -> PAUSE, song unchanged, reset_player stays 0.
